// File: rtl/decoder_8b10b_if.sv
// Symbol/decoded-byte bundle between a 10-bit symbol source and decoder_8b10b.
// The sync member is driven as constant 1 unless DEC_SYNC_FSM_EN is defined.
interface decoder_8b10b_if;
    logic       code_valid;
    logic [9:0] code;
    logic [7:0] data_out;
    logic       KO;
    logic       data_valid;
    logic       code_err;
    logic       disp_err;
    logic       rd_out;
    logic       sync;

    modport master (
        output code_valid, code,
        input  data_out, KO, data_valid, code_err, disp_err, rd_out, sync
    );

    modport slave (
        input  code_valid, code,
        output data_out, KO, data_valid, code_err, disp_err, rd_out, sync
    );
endinterface

// File: rtl/decoder_8b10b.sv
// Registered 8b/10b decoder with running-disparity tracking and error flags.
// Define DEC_SYNC_FSM_EN to build the comma-driven LOS/ACQ1/ACQ2/SYNC tracker.
module decoder_8b10b (
    input  logic           clk,
    input  logic           reset,
    decoder_8b10b_if.slave bus
);

    // abcdei -> {legal, EDCBA}; both RD columns of D.0-D.31 plus K.28
    function automatic logic [5:0] dec6(input logic [5:0] s);
        logic [5:0] r;
        case (s)
            6'b100111, 6'b011000: r = {1'b1, 5'd0};
            6'b011101, 6'b100010: r = {1'b1, 5'd1};
            6'b101101, 6'b010010: r = {1'b1, 5'd2};
            6'b110001:            r = {1'b1, 5'd3};
            6'b110101, 6'b001010: r = {1'b1, 5'd4};
            6'b101001:            r = {1'b1, 5'd5};
            6'b011001:            r = {1'b1, 5'd6};
            6'b111000, 6'b000111: r = {1'b1, 5'd7};
            6'b111001, 6'b000110: r = {1'b1, 5'd8};
            6'b100101:            r = {1'b1, 5'd9};
            6'b010101:            r = {1'b1, 5'd10};
            6'b110100:            r = {1'b1, 5'd11};
            6'b001101:            r = {1'b1, 5'd12};
            6'b101100:            r = {1'b1, 5'd13};
            6'b011100:            r = {1'b1, 5'd14};
            6'b010111, 6'b101000: r = {1'b1, 5'd15};
            6'b011011, 6'b100100: r = {1'b1, 5'd16};
            6'b100011:            r = {1'b1, 5'd17};
            6'b010011:            r = {1'b1, 5'd18};
            6'b110010:            r = {1'b1, 5'd19};
            6'b001011:            r = {1'b1, 5'd20};
            6'b101010:            r = {1'b1, 5'd21};
            6'b011010:            r = {1'b1, 5'd22};
            6'b111010, 6'b000101: r = {1'b1, 5'd23};
            6'b110011, 6'b001100: r = {1'b1, 5'd24};
            6'b100110:            r = {1'b1, 5'd25};
            6'b010110:            r = {1'b1, 5'd26};
            6'b110110, 6'b001001: r = {1'b1, 5'd27};
            6'b001110, 6'b001111,
            6'b110000:            r = {1'b1, 5'd28};
            6'b101110, 6'b010001: r = {1'b1, 5'd29};
            6'b011110, 6'b100001: r = {1'b1, 5'd30};
            6'b101011, 6'b010100: r = {1'b1, 5'd31};
            default:              r = {1'b0, 5'd0};
        endcase
        return r;
    endfunction

    // fghj -> {legal, alternate-7, HGF}
    function automatic logic [4:0] dec4(input logic [3:0] s);
        logic [4:0] r;
        case (s)
            4'b0100, 4'b1011: r = {2'b10, 3'd0};
            4'b1001:          r = {2'b10, 3'd1};
            4'b0101:          r = {2'b10, 3'd2};
            4'b0011, 4'b1100: r = {2'b10, 3'd3};
            4'b0010, 4'b1101: r = {2'b10, 3'd4};
            4'b1010:          r = {2'b10, 3'd5};
            4'b0110:          r = {2'b10, 3'd6};
            4'b0001, 4'b1110: r = {2'b10, 3'd7};
            4'b0111, 4'b1000: r = {2'b11, 3'd7};
            default:          r = {2'b00, 3'd0};
        endcase
        return r;
    endfunction

    logic [5:0] s6_s, r6_s;
    logic [3:0] s4_s, s4_lut_s;
    logic [4:0] r4_s;
    logic [2:0] ones6_s, ones4_s;
    logic       k28_s, k7_s, alt_ok_s, ko_s, cerr_s, derr_s, rd_mid_s, rd_new_s;
    logic       p6_s, n6_s, p4_s, n4_s, s6p_s, s6n_s, s4p_s, s4n_s;

    logic [7:0] data_q, data_d;
    logic       ko_q, ko_d, dvalid_q, dvalid_d, cerr_q, cerr_d, derr_q, derr_d, rd_q, rd_d;

    assign s6_s = {bus.code[0], bus.code[1], bus.code[2], bus.code[3], bus.code[4], bus.code[5]};
    assign s4_s = {bus.code[6], bus.code[7], bus.code[8], bus.code[9]};

    // Table lookup, K/alternate-7 legality and disparity against the current RD
    always_comb begin
        k28_s    = (s6_s == 6'b001111) || (s6_s == 6'b110000);
        // K28 at RD+ carries the complemented 4b code
        s4_lut_s = (s6_s == 6'b110000) ? ~s4_s : s4_s;
        r6_s     = dec6(s6_s);
        r4_s     = dec4(s4_lut_s);
        k7_s     = !k28_s && (r6_s[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30});
        alt_ok_s = ((s4_s == 4'b0111) && (r6_s[4:0] inside {5'd17, 5'd18, 5'd20})) ||
                   ((s4_s == 4'b1000) && (r6_s[4:0] inside {5'd11, 5'd13, 5'd14}));
        ko_s     = r6_s[5] && r4_s[4] && (k28_s || (k7_s && r4_s[3]));
        cerr_s   = !r6_s[5] || !r4_s[4] || (!k28_s && r4_s[3] && !k7_s && !alt_ok_s);

        ones6_s  = 3'($countones(s6_s));
        ones4_s  = 3'($countones(s4_s));
        p6_s     = ones6_s > 3'd3;
        n6_s     = ones6_s < 3'd3;
        p4_s     = ones4_s > 3'd2;
        n4_s     = ones4_s < 3'd2;
        s6p_s    = s6_s == 6'b000111;
        s6n_s    = s6_s == 6'b111000;
        s4p_s    = s4_s == 4'b0011;
        s4n_s    = s4_s == 4'b1100;
        rd_mid_s = (p6_s || s6p_s) ? 1'b1 : ((n6_s || s6n_s) ? 1'b0 : rd_q);
        rd_new_s = (p4_s || s4p_s) ? 1'b1 : ((n4_s || s4n_s) ? 1'b0 : rd_mid_s);
        derr_s   = (p6_s && rd_q) || (n6_s && !rd_q) || (s6p_s && !rd_q) || (s6n_s && rd_q) ||
                   (p4_s && rd_mid_s) || (n4_s && !rd_mid_s) ||
                   (s4p_s && !rd_mid_s) || (s4n_s && rd_mid_s);
    end

    // Output next-state: capture on a valid symbol, otherwise hold and clear flags
    always_comb begin
        data_d   = data_q;
        ko_d     = ko_q;
        rd_d     = rd_q;
        dvalid_d = 1'b0;
        cerr_d   = 1'b0;
        derr_d   = 1'b0;
        if (bus.code_valid) begin
            data_d   = {r4_s[2:0], r6_s[4:0]};
            ko_d     = ko_s;
            rd_d     = rd_new_s;
            dvalid_d = 1'b1;
            cerr_d   = cerr_s;
            derr_d   = derr_s;
        end else begin
            dvalid_d = 1'b0;
        end
    end

    // Output and running-disparity registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= 8'h00;
            ko_q     <= 1'b0;
            dvalid_q <= 1'b0;
            cerr_q   <= 1'b0;
            derr_q   <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            data_q   <= data_d;
            ko_q     <= ko_d;
            dvalid_q <= dvalid_d;
            cerr_q   <= cerr_d;
            derr_q   <= derr_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.KO         = ko_q;
    assign bus.data_valid = dvalid_q;
    assign bus.code_err   = cerr_q;
    assign bus.disp_err   = derr_q;
    assign bus.rd_out     = rd_q;

`ifdef DEC_SYNC_FSM_EN
    typedef enum logic [1:0] {LOS = 2'd0, ACQ1 = 2'd1, ACQ2 = 2'd2, SYNC = 2'd3} sync_state_e;

    sync_state_e state_q, state_d;
    logic [1:0]  err_cnt_q, err_cnt_d, good_cnt_q, good_cnt_d;
    logic        sync_q, comma_s, sym_err_s;

    assign sym_err_s = cerr_s || derr_s;
    assign comma_s   = k28_s && r4_s[4] && (r4_s[2:0] == 3'd5) && !sym_err_s;

    // Sync next-state; good_cnt counts clean symbols toward forgiving one error
    always_comb begin
        state_d    = state_q;
        err_cnt_d  = err_cnt_q;
        good_cnt_d = good_cnt_q;
        if (bus.code_valid) begin
            case (state_q)
                LOS:  state_d = comma_s ? ACQ1 : LOS;
                ACQ1: state_d = sym_err_s ? LOS : (comma_s ? ACQ2 : ACQ1);
                ACQ2: state_d = sym_err_s ? LOS : (comma_s ? SYNC : ACQ2);
                SYNC: begin
                    if (sym_err_s) begin
                        good_cnt_d = 2'd0;
                        if (err_cnt_q == 2'd3) begin
                            state_d   = LOS;
                            err_cnt_d = 2'd0;
                        end else begin
                            err_cnt_d = err_cnt_q + 2'd1;
                        end
                    end else if (err_cnt_q != 2'd0) begin
                        if (good_cnt_q == 2'd3) begin
                            err_cnt_d  = err_cnt_q - 2'd1;
                            good_cnt_d = 2'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 2'd1;
                        end
                    end else begin
                        good_cnt_d = 2'd0;
                    end
                end
                default: begin
                    state_d    = LOS;
                    err_cnt_d  = 2'd0;
                    good_cnt_d = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sync state registers; sync flag shares the data_out latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOS;
            err_cnt_q  <= 2'd0;
            good_cnt_q <= 2'd0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_cnt_q  <= err_cnt_d;
            good_cnt_q <= good_cnt_d;
            sync_q     <= (state_d == SYNC);
        end
    end

    assign bus.sync = sync_q;
`else
    assign bus.sync = 1'b1;
`endif

endmodule
